// File: rtl/mem_line_requester.sv
// Cache-line miss requester: optional dirty-victim writeback, then a line fill, then a one-cycle response.
// Define MEM_REQ_STATS_EN to add the fill_count / wb_count statistics outputs.
module mem_line_requester #(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [25:0]  req_addr,
    input  logic         req_evict,
    input  logic [25:0]  evict_addr,
    input  logic [127:0] evict_data,
    output logic         resp_valid,
    output logic [25:0]  resp_addr,
    output logic [127:0] resp_data,
    output logic [25:0]  mem_addr,
    output logic [127:0] mem_wdata,
    output logic         mem_we,
    input  logic [127:0] mem_rdata,
    output logic         busy
`ifdef MEM_REQ_STATS_EN
    ,
    output logic [15:0]  fill_count,
    output logic [15:0]  wb_count
`endif
);

    localparam int AW = 26;
    localparam int DW = 128;
    localparam int CW = 8;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          evict;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
    } req_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    req_t          cap, cap_n;

    logic          req_ready_n;
    logic          resp_valid_n;
    logic [AW-1:0] resp_addr_n;
    logic [DW-1:0] resp_data_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n;
    logic          mem_we_n;
    logic          busy_n;

    // Every output is computed one cycle ahead so the RAM sees registered address/data.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        cap_n        = cap;
        req_ready_n  = 1'b0;
        resp_valid_n = 1'b0;
        resp_addr_n  = resp_addr;
        resp_data_n  = resp_data;
        mem_addr_n   = '0;
        mem_wdata_n  = '0;
        mem_we_n     = 1'b0;

        case (state)
            IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    cap_n.addr  = req_addr;
                    cap_n.evict = req_evict;
                    cap_n.eaddr = evict_addr;
                    cap_n.edata = evict_data;
                    cnt_n       = CNT_LOAD;
                    req_ready_n = 1'b0;
                    if (req_evict) begin
                        state_n     = WB;
                        mem_addr_n  = evict_addr;
                        mem_wdata_n = evict_data;
                        mem_we_n    = 1'b1;
                    end else begin
                        state_n    = FILL;
                        mem_addr_n = req_addr;
                    end
                end
            end
            WB: begin
                if (cnt == '0) begin
                    state_n    = FILL;
                    cnt_n      = CNT_LOAD;
                    mem_addr_n = cap.addr;
                end else begin
                    cnt_n       = cnt - 1'b1;
                    mem_addr_n  = cap.eaddr;
                    mem_wdata_n = cap.edata;
                    mem_we_n    = 1'b1;
                end
            end
            FILL: begin
                if (cnt == '0) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_addr_n  = cap.addr;
                    resp_data_n  = mem_rdata;
                end else begin
                    cnt_n      = cnt - 1'b1;
                    mem_addr_n = cap.addr;
                end
            end
            RESP: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_data  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cap        <= cap_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_addr  <= resp_addr_n;
            resp_data  <= resp_data_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_we     <= mem_we_n;
            busy       <= busy_n;
        end
    end

`ifdef MEM_REQ_STATS_EN
    logic fill_done, wb_done;
    assign fill_done = (state == FILL) && (cnt == '0);
    assign wb_done   = (state == WB) && (cnt == '0);

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_count <= '0;
            wb_count   <= '0;
        end else begin
            if (fill_done) fill_count <= fill_count + 16'd1;
            if (wb_done)   wb_count   <= wb_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_line_requester.sv
// Directed bench for mem_line_requester: one instance at MEM_LATENCY=4 against a small RAM model,
// one at MEM_LATENCY=1 returning an address-derived line.
module tb_mem_line_requester;
    localparam int M = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         req_valid, req_valid_1;
    logic [25:0]  req_addr, evict_addr;
    logic         req_evict;
    logic [127:0] evict_data;

    logic         req_ready, resp_valid, mem_we, busy;
    logic [25:0]  resp_addr, mem_addr;
    logic [127:0] resp_data, mem_wdata, mem_rdata;

    logic         req_ready_1, resp_valid_1, mem_we_1, busy_1;
    logic [25:0]  resp_addr_1, mem_addr_1;
    logic [127:0] resp_data_1, mem_wdata_1, mem_rdata_1;

`ifdef MEM_REQ_STATS_EN
    logic [15:0] fill_count, wb_count, fill_count_1, wb_count_1;
`endif

    mem_line_requester #(.MEM_LATENCY(M)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_evict(req_evict), .evict_addr(evict_addr), .evict_data(evict_data),
        .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_data(resp_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_REQ_STATS_EN
        , .fill_count(fill_count), .wb_count(wb_count)
`endif
    );

    mem_line_requester #(.MEM_LATENCY(1)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_addr(req_addr),
        .req_evict(req_evict), .evict_addr(evict_addr), .evict_data(evict_data),
        .resp_valid(resp_valid_1), .resp_addr(resp_addr_1), .resp_data(resp_data_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_we(mem_we_1),
        .mem_rdata(mem_rdata_1), .busy(busy_1)
`ifdef MEM_REQ_STATS_EN
        , .fill_count(fill_count_1), .wb_count(wb_count_1)
`endif
    );

    // RAM model: untouched lines return a fixed pattern, written lines return what was written.
    function automatic logic [127:0] init_line(input logic [5:0] a);
        if (a == 6'h10) return {32'd3, 32'd2, 32'd1, 32'd0};
        return {4{{26'd0, a}}};
    endfunction

    logic [127:0] ram [0:63];
    logic [63:0]  wr_vld = '0;
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[5:0]]    <= mem_wdata;
            wr_vld[mem_addr[5:0]] <= 1'b1;
        end
    end
    assign mem_rdata   = wr_vld[mem_addr[5:0]] ? ram[mem_addr[5:0]] : init_line(mem_addr[5:0]);
    assign mem_rdata_1 = {102'd0, mem_addr_1};

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are observed 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Waits (bounded) for resp_valid, counting writeback and fill cycles seen on the RAM port.
    task automatic wait_resp(input logic [25:0] wa, input logic [127:0] wd, input logic [25:0] ra,
                             output int rc, output int nwe, output int nrd);
        rc = -1; nwe = 0; nrd = 0;
        for (int k = 0; k < 64; k++) begin
            if (resp_valid) begin
                rc = cyc;
                break;
            end
            if (mem_we && mem_addr == wa && mem_wdata == wd) nwe++;
            if (!mem_we && busy && mem_addr == ra && mem_wdata == '0) nrd++;
            tick();
        end
    endtask

    // Full transaction on u0: handshake, phase counts, latency, response, return to idle.
    task automatic txn(input string tag, input logic [25:0] ra, input logic ev,
                       input logic [25:0] ea, input logic [127:0] ed, input logic [127:0] exp_data);
        int hs, rc, nwe, nrd;
        req_addr = ra; req_evict = ev; evict_addr = ea; evict_data = ed; req_valid = 1'b1;
        chk({tag, "_ready"}, req_ready, 1'b1);
        tick();
        hs = cyc;
        req_valid = 1'b0;
        wait_resp(ea, ed, ra, rc, nwe, nrd);
        chk({tag, "_lat"}, rc - hs, ev ? 2 * M : M);
        chk({tag, "_wb_cycles"}, nwe, ev ? M : 0);
        chk({tag, "_fill_cycles"}, nrd, M);
        chk({tag, "_resp_addr"}, resp_addr, ra);
        chk({tag, "_resp_data"}, resp_data, exp_data);
        tick();
        chk({tag, "_pulse_end"}, resp_valid, 1'b0);
        chk({tag, "_idle"}, {busy, req_ready, mem_we}, 3'b010);
        chk({tag, "_hold"}, resp_data, exp_data);
    endtask

    initial begin
        int hs, rc, nwe, nrd, seen;
        reset = 1'b0; req_valid = 1'b0; req_valid_1 = 1'b0;
        req_addr = '0; req_evict = 1'b0; evict_addr = '0; evict_data = '0;
        tick(); tick();
        chk("rst_outs", {resp_valid, mem_we, busy, req_ready}, 4'b0001);
        chk("rst_data", {resp_addr, resp_data, mem_addr, mem_wdata}, '0);
        reset = 1'b1;
        tick();
        chk("post_rst", {req_ready, busy, req_ready_1, busy_1}, 4'b1010);

        txn("plain", 26'h10, 1'b0, 26'h0, 128'h0, {32'd3, 32'd2, 32'd1, 32'd0});
        txn("evict", 26'h3, 1'b1, 26'h2, {16{8'hA5}}, {4{32'h3}});
        txn("rdback", 26'h2, 1'b0, 26'h0, 128'h0, {16{8'hA5}});
`ifdef MEM_REQ_STATS_EN
        chk("fill_count", fill_count, 16'd3);
        chk("wb_count", wb_count, 16'd1);
`endif
        txn("same", 26'h5, 1'b1, 26'h5, 128'h1234, 128'h1234);

        // req_valid held across the transaction with a new address
        req_addr = 26'h10; req_evict = 1'b0; req_valid = 1'b1;
        tick();
        hs = cyc;
        req_addr = 26'h7;
        wait_resp(26'h3FFFFFF, '1, 26'h10, rc, nwe, nrd);
        chk("hold_lat", rc - hs, M);
        chk("hold_fill_cycles", nrd, M);
        chk("hold_resp_addr", resp_addr, 26'h10);
        chk("hold_ready_in_resp", req_ready, 1'b0);
        tick();
        chk("hold_idle", {busy, req_ready, mem_addr}, {1'b0, 1'b1, 26'h0});
        tick();
        chk("hold_accept", {busy, mem_addr}, {1'b1, 26'h7});
        req_valid = 1'b0;
        wait_resp(26'h3FFFFFF, '1, 26'h7, rc, nwe, nrd);
        chk("hold2_resp", {resp_addr, resp_data}, {26'h7, {4{32'h7}}});
        tick();

        // reset during the second fill cycle
        req_addr = 26'h9; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rfill_busy", {busy, mem_addr}, {1'b1, 26'h9});
        reset = 1'b0;
        tick();
        chk("rfill_outs", {busy, mem_we, resp_valid, req_ready, mem_addr}, {4'b0001, 26'h0});
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (resp_valid) seen++;
        end
        chk("rfill_no_resp", seen, 0);
        chk("rfill_ready", req_ready, 1'b1);
`ifdef MEM_REQ_STATS_EN
        chk("stats_cleared", {fill_count, wb_count}, 32'h0);
`endif

        // reset during writeback
        req_addr = 26'hB; req_evict = 1'b1; evict_addr = 26'hA; evict_data = '1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rwb_we", {mem_we, mem_addr}, {1'b1, 26'hA});
        reset = 1'b0;
        tick();
        chk("rwb_we_low", {mem_we, busy}, 2'b00);
        reset = 1'b1;
        tick();

        // MEM_LATENCY=1 instance
        req_addr = 26'h21; req_evict = 1'b0; req_valid_1 = 1'b1;
        tick();
        req_valid_1 = 1'b0;
        chk("l1_fill", {busy_1, mem_we_1, mem_addr_1}, {2'b10, 26'h21});
        tick();
        chk("l1_resp", {resp_valid_1, resp_addr_1, resp_data_1}, {1'b1, 26'h21, 102'd0, 26'h21});
        tick();
        chk("l1_pulse_end", {resp_valid_1, req_ready_1, busy_1}, 3'b010);
        req_addr = 26'h31; req_evict = 1'b1; evict_addr = 26'h30; evict_data = 128'h55; req_valid_1 = 1'b1;
        tick();
        req_valid_1 = 1'b0;
        chk("l1_wb", {mem_we_1, mem_addr_1, mem_wdata_1}, {1'b1, 26'h30, 128'h55});
        tick();
        chk("l1_wb_fill", {mem_we_1, mem_addr_1}, {1'b0, 26'h31});
        tick();
        chk("l1_evict_resp", {resp_valid_1, resp_data_1}, {1'b1, 102'd0, 26'h31});
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_line_requester.md
MEM_LINE_REQUESTER -- requirements
Module: mem_line_requester

Interface
REQ-001 Parameter MEM_LATENCY, default 4: cycles each memory phase (writeback or fill) holds address/data stable before completion; legal range 1..255.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; 0 = reset, sampled on rising clk.
REQ-004 req_valid  in  1  cache miss request valid.
REQ-005 req_ready  out  1  requester can accept a request this cycle.
REQ-006 req_addr  in  26  line address to fill.
REQ-007 req_evict  in  1  dirty victim must be written back before fill.
REQ-008 evict_addr  in  26  victim line address.
REQ-009 evict_data  in  128  victim line data.
REQ-010 resp_valid  out  1  one-cycle pulse: fill data available.
REQ-011 resp_addr  out  26  line address of returned fill.
REQ-012 resp_data  out  128  filled line data.
REQ-013 mem_addr  out  26  line address to RAM (drives its data_requested).
REQ-014 mem_wdata  out  128  line write data to RAM.
REQ-015 mem_we  out  1  RAM write enable.
REQ-016 mem_rdata  in  128  line read data from RAM (combinational return).
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, WB, FILL, RESP; all outputs registered.
REQ-019 IDLE: req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0; handshake = req_valid & req_ready.
REQ-020 On handshake, req_addr, req_evict, evict_addr, evict_data captured; next state WB if req_evict else FILL; phase counter loaded with MEM_LATENCY-1.
REQ-021 req_ready=0 in WB, FILL, RESP; req_valid there is ignored and nothing is captured.
REQ-022 WB: mem_addr=captured evict_addr, mem_wdata=captured evict_data, mem_we=1 for exactly MEM_LATENCY cycles; on counter 0 go FILL, reload counter.
REQ-023 FILL: mem_addr=captured req_addr, mem_we=0, mem_wdata=0 for exactly MEM_LATENCY cycles; on counter-0 cycle mem_rdata sampled into resp_data; go RESP.
REQ-024 RESP: resp_valid=1 for exactly one cycle with resp_addr=captured req_addr; next state IDLE; resp_data/resp_addr hold until next RESP.
REQ-025 Latency, handshake at cycle T: no evict -> resp_valid at T+MEM_LATENCY+1; evict -> T+2*MEM_LATENCY+1.
REQ-026 Next handshake earliest one cycle after resp_valid (back in IDLE).
REQ-027 evict_addr == req_addr: WB then FILL still performed; resp_data equals written evict_data.
REQ-028 MEM_LATENCY=1: WB and FILL each one cycle; counter never underflows.
REQ-029 mem_we never high outside WB; never high in the same cycle as a FILL address.

Reset
REQ-030 reset=0 at a rising edge forces IDLE regardless of state, including mid-WB/FILL; in-flight request dropped, no resp_valid issued.
REQ-031 Reset values: req_ready=1 on the first cycle after reset release, resp_valid=0, resp_addr=0, resp_data=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, counter=0.
REQ-032 Reset mid-WB: mem_we low from the cycle following the reset edge; partial RAM contents unspecified.

Configuration
REQ-033 Macro MEM_REQ_STATS_EN defined: extra outputs fill_count (16) and wb_count (16), incremented on entry to RESP and on WB completion respectively, wrap 0xFFFF->0, cleared by reset.
REQ-034 MEM_REQ_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-035 MEM_LATENCY=4, req_addr=0x10, no evict, RAM line 0x10 = {3,2,1,0}x32b -> mem_addr=0x10 for 4 cycles, resp_valid at T+5, resp_data=0x00000003_00000002_00000001_00000000.
REQ-036 req_evict=1, evict_addr=0x2, evict_data=all 0xA5, req_addr=0x3 -> mem_we=1 at 0x2 for 4 cycles, then read 0x3, resp_valid at T+9; later read of 0x2 returns all 0xA5.
REQ-037 evict_addr=req_addr=0x5, evict_data=0x1234 -> resp_data=0x1234 at T+9.
REQ-038 req_valid held high during FILL with new addr 0x7 -> ignored; 0x7 accepted only after resp_valid, in IDLE.
REQ-039 reset=0 at second FILL cycle -> next cycle IDLE, mem_we=0, no resp_valid pulse, req_ready=1 after release.
REQ-040 MEM_REQ_STATS_EN defined, 3 fills (1 with evict) -> fill_count=3, wb_count=1; MEM_LATENCY=1 run -> resp_valid at T+2 (no evict).
